// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, issues instruction-memory requests,
// captures fetched words and drives the PC-latch load strobe and next-PC value.
module fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180,
    parameter int unsigned MAX_WAIT     = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        exception,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic        pc_enable,
    output logic [31:0] pc_next,
    output logic [31:0] pc_current,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic        fetch_timeout
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        timeout_q, timeout_d;
    logic [7:0]  wait_q, wait_d;

    logic        in_fetch, in_hold;
    logic        redir_req, redir;
    logic        advance;

    assign in_fetch = (state_q == S_FETCH);
    assign in_hold  = (state_q == S_HOLD);

    // Stall only masks jump/branch; an exception always wins.
    assign redir_req = exception | ((jump | branch_taken) & ~stall);
    assign redir     = redir_req & (in_fetch | in_hold);

    always_comb begin
        pc_next = pc_q + 32'd4;
        if (redir_req) begin
            if (exception)
                pc_next = EXC_VECTOR;
            else if (jump)
                pc_next = jump_target;
            else
                pc_next = branch_target;
        end
    end

    assign advance   = (in_fetch & imem_ready & ~stall) | (in_hold & ~stall);
    assign pc_enable = redir | advance;

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        timeout_d = timeout_q;
        wait_d    = wait_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (redir) begin
                    valid_d = 1'b0;
                    wait_d  = 8'd0;
                end else if (imem_ready) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    wait_d  = 8'd0;
                    state_d = stall ? S_HOLD : S_FETCH;
                end else begin
                    valid_d = 1'b0;
                    wait_d  = sat_inc(wait_q);
                    if (wait_d == WAIT_LIMIT)
                        timeout_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redir) begin
                    valid_d = 1'b0;
                    wait_d  = 8'd0;
                    state_d = S_FETCH;
                end else if (!stall) begin
                    valid_d = 1'b0;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_VECTOR;
            instr_q   <= 32'd0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            wait_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            wait_q    <= wait_d;
            if (pc_enable)
                pc_q <= pc_next;
        end
    end

    assign imem_req      = in_fetch;
    assign imem_addr     = pc_q;
    assign pc_current    = pc_q;
    assign instr_valid   = valid_q;
    assign instr         = instr_q;
    assign fetch_timeout = timeout_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed, table-driven bench for fetch_sequencer plus hand-written reset and
// IDLE-redirect sequences.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        stall, branch_taken, jump, exception, imem_ready;
    logic [31:0] branch_target, jump_target, imem_rdata;
    logic        imem_req, pc_enable, instr_valid, fetch_timeout;
    logic [31:0] imem_addr, pc_next, pc_current, instr;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_sequencer dut (
        .clock        (clk),
        .reset        (rst),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .exception    (exception),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .pc_enable    (pc_enable),
        .pc_next      (pc_next),
        .pc_current   (pc_current),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .fetch_timeout(fetch_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        stall, br, jmp, exc, rdy;
        logic [31:0] btgt, jtgt, rdata;
        logic        e_req, e_en, e_vld, e_to;
        logic [31:0] e_addr, e_next, e_instr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic stall_v, input logic br, input logic [31:0] btgt,
        input logic jmp, input logic [31:0] jtgt, input logic exc,
        input logic rdy, input logic [31:0] rdata,
        input logic e_req, input logic [31:0] e_addr, input logic e_en,
        input logic [31:0] e_next, input logic e_vld, input logic [31:0] e_instr,
        input logic e_to);
        vec_t v;
        v.stall = stall_v; v.br = br; v.btgt = btgt; v.jmp = jmp; v.jtgt = jtgt;
        v.exc = exc; v.rdy = rdy; v.rdata = rdata;
        v.e_req = e_req; v.e_addr = e_addr; v.e_en = e_en; v.e_next = e_next;
        v.e_vld = e_vld; v.e_instr = e_instr; v.e_to = e_to;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        stall = 0; branch_taken = 0; jump = 0; exception = 0; imem_ready = 0;
        branch_target = '0; jump_target = '0; imem_rdata = '0;
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();

        // Columns: stall br btgt jmp jtgt exc rdy rdata | req addr en next vld instr to
        vecs.push_back(mk(0,0,0,0,0,0,1,32'hA000_0000, 0,32'h0,0,32'h4,0,32'h0,0));           // IDLE
        vecs.push_back(mk(0,0,0,0,0,0,1,32'hA000_0000, 1,32'h0,1,32'h4,0,32'h0,0));
        vecs.push_back(mk(0,0,0,0,0,0,1,32'hA000_0004, 1,32'h4,1,32'h8,1,32'hA000_0000,0));
        vecs.push_back(mk(1,0,0,0,0,0,1,32'hA000_0008, 1,32'h8,0,32'hC,1,32'hA000_0004,0));    // stall at PC 8
        vecs.push_back(mk(1,0,0,0,0,0,1,32'h5555_5555, 0,32'h8,0,32'hC,1,32'hA000_0008,0));    // HOLD
        vecs.push_back(mk(1,0,0,0,0,0,1,32'h5555_5555, 0,32'h8,0,32'hC,1,32'hA000_0008,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,32'h0,         0,32'h8,1,32'hC,1,32'hA000_0008,0));    // release
        vecs.push_back(mk(0,1,32'h200,1,32'h400,0,1,32'hA000_000C, 1,32'hC,1,32'h400,0,32'hA000_0008,0));
        vecs.push_back(mk(0,1,32'h200,1,32'h400,1,1,32'hA000_0400, 1,32'h400,1,32'h8000_0180,0,32'hA000_0008,0));
        vecs.push_back(mk(1,1,32'h200,0,0,0,1,32'hA000_0180, 1,32'h8000_0180,0,32'h8000_0184,0,32'hA000_0008,0));
        vecs.push_back(mk(0,1,32'h200,0,0,0,0,32'h0,   0,32'h8000_0180,1,32'h200,1,32'hA000_0180,0));
        vecs.push_back(mk(1,0,0,0,0,1,0,32'h0,         1,32'h200,1,32'h8000_0180,0,32'hA000_0180,0));
        for (int i = 0; i < 15; i++)
            vecs.push_back(mk(0,0,0,0,0,0,0,32'h0, 1,32'h8000_0180,0,32'h8000_0184,0,32'hA000_0180,0));
        vecs.push_back(mk(0,0,0,0,0,0,1,32'h1234_5678, 1,32'h8000_0180,1,32'h8000_0184,0,32'hA000_0180,1));
        vecs.push_back(mk(0,0,0,0,0,0,1,32'hDEAD_BEEF, 1,32'h8000_0184,1,32'h8000_0188,1,32'h1234_5678,1));
        vecs.push_back(mk(0,0,0,1,32'hFFFF_FFFC,0,0,32'h0, 1,32'h8000_0188,1,32'hFFFF_FFFC,1,32'hDEAD_BEEF,1));
        vecs.push_back(mk(0,0,0,0,0,0,1,32'h0000_0013, 1,32'hFFFF_FFFC,1,32'h0,0,32'hDEAD_BEEF,1));
        vecs.push_back(mk(0,0,0,0,0,0,1,32'h0000_0093, 1,32'h0,1,32'h4,1,32'h0000_0013,1));
        vecs.push_back(mk(0,0,0,0,0,0,0,32'h0,         1,32'h4,0,32'h8,1,32'h0000_0093,1));

        @(negedge clk);
        chk("rst_req",     {31'd0, imem_req},      32'd0);
        chk("rst_en",      {31'd0, pc_enable},     32'd0);
        chk("rst_pc",      pc_current,             32'h0);
        chk("rst_vld",     {31'd0, instr_valid},   32'd0);
        chk("rst_instr",   instr,                  32'h0);
        chk("rst_timeout", {31'd0, fetch_timeout}, 32'd0);

        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            stall = vecs[i].stall; branch_taken = vecs[i].br; branch_target = vecs[i].btgt;
            jump = vecs[i].jmp; jump_target = vecs[i].jtgt; exception = vecs[i].exc;
            imem_ready = vecs[i].rdy; imem_rdata = vecs[i].rdata;
            @(negedge clk);
            chk($sformatf("v%0d_req", i),     {31'd0, imem_req},      {31'd0, vecs[i].e_req});
            chk($sformatf("v%0d_addr", i),    imem_addr,              vecs[i].e_addr);
            chk($sformatf("v%0d_en", i),      {31'd0, pc_enable},     {31'd0, vecs[i].e_en});
            chk($sformatf("v%0d_next", i),    pc_next,                vecs[i].e_next);
            chk($sformatf("v%0d_vld", i),     {31'd0, instr_valid},   {31'd0, vecs[i].e_vld});
            chk($sformatf("v%0d_instr", i),   instr,                  vecs[i].e_instr);
            chk($sformatf("v%0d_timeout", i), {31'd0, fetch_timeout}, {31'd0, vecs[i].e_to});
            @(posedge clk); #1;
        end

        // Asynchronous reset between edges while waiting on memory at PC 4.
        drive_idle();
        #1 rst = 1'b1;
        #1;
        chk("amid_pc",      pc_current,             32'h0);
        chk("amid_req",     {31'd0, imem_req},      32'd0);
        chk("amid_en",      {31'd0, pc_enable},     32'd0);
        chk("amid_vld",     {31'd0, instr_valid},   32'd0);
        chk("amid_timeout", {31'd0, fetch_timeout}, 32'd0);

        // Redirects are ignored while IDLE.
        @(posedge clk); #1;
        rst = 1'b0;
        jump = 1'b1; jump_target = 32'h0000_0777;
        @(negedge clk);
        chk("idle_jump_en", {31'd0, pc_enable}, 32'd0);
        @(posedge clk); #1;
        jump = 1'b0;
        @(negedge clk);
        chk("idle_jump_pc",  pc_current,        32'h0);
        chk("idle_exit_req", {31'd0, imem_req}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller that sequences the program-counter latch.
- Owns the architectural PC copy, issues instruction-memory requests, and waits for memory ready.
- Captures the fetched word and produces the PC-latch `pc_enable` and `pc_next` controls.
- Arbitrates next-PC sources (exception > jump > branch > sequential) and holds fetch during pipeline stalls.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- EXC_VECTOR, 32'h8000_0180, exception handler address.
- MAX_WAIT, 15, FETCH cycles without `imem_ready` before `fetch_timeout` is set (range 1..255).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- stall  in  1  downstream cannot accept an instruction; hold PC.
- branch_taken  in  1  one-cycle redirect to `branch_target`.
- branch_target  in  32  branch destination.
- jump  in  1  one-cycle redirect to `jump_target`.
- jump_target  in  32  jump destination.
- exception  in  1  one-cycle redirect to EXC_VECTOR.
- imem_ready  in  1  `imem_rdata` is valid this cycle.
- imem_rdata  in  32  fetched instruction word.
- imem_req  out  1  fetch request; combinational, = (state==FETCH).
- imem_addr  out  32  = `pc_current`.
- pc_enable  out  1  combinational load strobe to the PC latch.
- pc_next  out  32  combinational next-PC value for the PC latch.
- pc_current  out  32  registered current PC.
- instr_valid  out  1  registered; `instr` is valid.
- instr  out  32  registered captured instruction.
- fetch_timeout  out  1  sticky error flag.

Behaviour:
- **Reset (async):**
  - `pc_current`=RESET_VECTOR, state=IDLE, `instr`=0, `instr_valid`=0, `fetch_timeout`=0, wait counter=0.
  - Therefore `imem_req`=0 and `pc_enable`=0 during reset.
- **States:** IDLE, FETCH, HOLD.
- **IDLE:** goes to FETCH on the first edge after reset deasserts. Redirects are ignored in IDLE.
- **Redirect condition (redir):**
  - redir = `exception` | ((`jump` | `branch_taken`) & ~`stall`).
  - Target priority: EXC_VECTOR > `jump_target` > `branch_target`.
  - `branch_taken`/`jump` arriving while `stall`=1 are ignored; upstream re-asserts them.
  - `exception` overrides `stall`.
- **`pc_next` mux:**
  - redir → selected target.
  - Otherwise → `pc_current` + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- **`pc_enable`** = 1 in FETCH or HOLD when any of:
  - redir;
  - FETCH & `imem_ready` & ~`stall`;
  - HOLD & ~`stall`.
  - On every edge with `pc_enable`=1, `pc_current` <= `pc_next`.
- **FETCH:**
  - `imem_ready` & ~redir & ~`stall`: `instr` <= `imem_rdata`, `instr_valid` <= 1, PC advances, stay in FETCH (back-to-back fetches, 1 instr/cycle).
  - `imem_ready` & ~redir & `stall`: `instr` <= `imem_rdata`, `instr_valid` <= 1, PC holds, go to HOLD.
  - No `imem_ready`: `instr_valid` <= 0, wait counter increments (saturates at 255). When counter == MAX_WAIT, `fetch_timeout` <= 1; keep requesting.
  - Wait counter clears on every `imem_ready` or redir.
- **HOLD:**
  - `instr` and `instr_valid`=1 held.
  - ~`stall`: PC advances by 4, `instr_valid` <= 0, go to FETCH.
- **Redirect in FETCH or HOLD:**
  - `instr_valid` <= 0 (squash); any same-cycle `imem_ready` data is discarded; state <= FETCH.
  - The first request to the target issues the next cycle.
- **Fetch latency:** address → `instr_valid` = 1 cycle after `imem_ready`.
- **`fetch_timeout`** clears only on reset.
- **Reset mid-fetch:** outstanding request abandoned; `imem_req` drops immediately (async).

Test Plan:
- Reset release, `imem_ready` tied 1, `stall`=0 → `imem_addr` sequence 0, 4, 8, 12 on consecutive cycles; `instr_valid`=1 from the cycle after the first ready; `pc_enable`=1 every FETCH cycle.
- `stall`=1 for 3 cycles coincident with ready at PC=8 → state HOLD, `instr` held, `pc_current` stays 8, `pc_enable`=0; after `stall` drops, next `imem_addr`=12.
- `jump`=1 with `jump_target`=32'h400 and `branch_taken`=1 in the same cycle → `pc_next`=32'h400, squash (`instr_valid`=0 next cycle), next `imem_addr`=32'h400. Repeat with `exception`=1 also asserted → 32'h8000_0180.
- `branch_taken` while `stall`=1 → ignored, PC unchanged. `exception` while `stall`=1 → PC=EXC_VECTOR the next cycle.
- `imem_ready` held low 15 cycles (MAX_WAIT=15) → `fetch_timeout`=1 and remains 1 after ready returns; cleared only by `reset`.
- PC=32'hFFFF_FFFC fetch completes → `pc_current`=0. Assert `reset` mid-wait (between edges) → `pc_current`=RESET_VECTOR and `imem_req`=0 immediately.
